// File: rtl/pe_row_sequencer_pkg.sv
// Shared types and helpers for the oBTC PE row sequencer (package obtc_pkg).
// Build option OBTC_HEAVYHASH_POST_EN is handled in pe_row_sequencer.sv.
package obtc_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int PE_OUT_W    = 14;
  localparam int MAX_DATA_W  = 1024;
  localparam int MAX_SLICE_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    GAP,
    STREAM,
    DRAIN,
    OUT
  } seq_state_t;

  // Beat k of a nibble-packed word: nibbles [k*wcount, (k+1)*wcount), lowest nibble first.
  function automatic logic [MAX_SLICE_W-1:0] beat_slice(input logic [MAX_DATA_W-1:0] data,
                                                        input int unsigned k,
                                                        input int unsigned wcount);
    logic [MAX_DATA_W-1:0] shifted;
    shifted = data >> (k * wcount * NIBBLE_W);
    return shifted[MAX_SLICE_W-1:0] & ~({MAX_SLICE_W{1'b1}} << (wcount * NIBBLE_W));
  endfunction

endpackage

// File: rtl/pe_row_sequencer_if.sv
// Bus bundle between the row sequencer (master) and its buffers, PE and result sink (slave).
// Build option OBTC_HEAVYHASH_POST_EN does not change this bundle.
interface pe_row_sequencer_if
  import obtc_pkg::*;
#(
    parameter int WCOUNT = 4,
    parameter int VLEN   = 64,
    parameter int ROWS   = 64
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // All handshakes: a transfer happens on a rising edge where valid && ready; valid and
  // its data stay stable until that edge, and ready never depends on valid.
  logic                       vec_valid;
  logic                       vec_ready;
  logic [VLEN*NIBBLE_W-1:0]   vec_data;
  logic                       row_valid;
  logic                       row_ready;
  logic [VLEN*NIBBLE_W-1:0]   row_data;
  logic [WCOUNT*NIBBLE_W-1:0] pe_M;
  logic [WCOUNT*NIBBLE_W-1:0] pe_X;
  logic                       pe_en;
  logic                       pe_clr;
  logic [PE_OUT_W-1:0]        pe_out;
  logic                       res_valid;
  logic                       res_ready;
  logic [PE_OUT_W-1:0]        res_data;
  logic [ROW_W-1:0]           res_row;
  logic                       done;
  seq_state_t                 dbg_state;

  modport master (
    input  vec_valid, vec_data, row_valid, row_data, pe_out, res_ready,
    output vec_ready, row_ready, pe_M, pe_X, pe_en, pe_clr,
           res_valid, res_data, res_row, done, dbg_state
  );

  modport slave (
    output vec_valid, vec_data, row_valid, row_data, pe_out, res_ready,
    input  vec_ready, row_ready, pe_M, pe_X, pe_en, pe_clr,
           res_valid, res_data, res_row, done, dbg_state
  );

endinterface

// File: rtl/pe_row_sequencer.sv
// Streams one matrix row and the SHA3 vector into a PE, drains it, and returns the row dot-product.
// Define OBTC_HEAVYHASH_POST_EN to return only the HeavyHash 4-bit product (pe_out >> 10).
module pe_row_sequencer
  import obtc_pkg::*;
#(
    parameter int WCOUNT = 4,
    parameter int VLEN   = 64,
    parameter int ROWS   = 64,
    parameter int PE_LAT = 3
) (
    input logic               clk,
    input logic               rst,
    pe_row_sequencer_if.master bus
);
  localparam int BEATS   = VLEN / WCOUNT;
  localparam int BEAT_W  = WCOUNT * NIBBLE_W;
  localparam int DATA_W  = VLEN * NIBBLE_W;
  localparam int CNT_MAX = (BEATS > PE_LAT) ? BEATS : PE_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(PE_LAT - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

  seq_state_t          state, next_state;
  logic [DATA_W-1:0]   vec_q, row_q;
  logic [CNT_W-1:0]    beat_cnt;
  logic [ROW_W-1:0]    row_cnt;
  logic [PE_OUT_W-1:0] res_q, res_cap;
  logic                cap_done, done_q;
  logic                vec_fire, row_fire, res_fire;
  logic [BEAT_W-1:0]   m_beat, x_beat;

  assign vec_fire = bus.vec_valid && (state == IDLE);
  assign row_fire = bus.row_valid && (state == LOAD);
  assign res_fire = bus.res_ready && (state == OUT) && cap_done;

  assign m_beat = BEAT_W'(beat_slice(MAX_DATA_W'(row_q), 32'(beat_cnt), 32'(WCOUNT)));
  assign x_beat = BEAT_W'(beat_slice(MAX_DATA_W'(vec_q), 32'(beat_cnt), 32'(WCOUNT)));

`ifdef OBTC_HEAVYHASH_POST_EN
  assign res_cap = {{(PE_OUT_W - NIBBLE_W){1'b0}}, bus.pe_out[PE_OUT_W-1 -: NIBBLE_W]};
`else
  assign res_cap = bus.pe_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.vec_valid) next_state = LOAD;
      LOAD:    if (bus.row_valid) next_state = CLR;
      CLR:     next_state = GAP;
      GAP:     next_state = STREAM;
      STREAM:  if (beat_cnt == LAST_BEAT) next_state = DRAIN;
      DRAIN:   if (beat_cnt == LAST_DRAIN) next_state = OUT;
      OUT:     if (res_fire) next_state = (row_cnt == LAST_ROW) ? IDLE : LOAD;
      default: next_state = IDLE;
    endcase
  end

  // pe_out only holds the final sum after the last drain edge, so the first OUT cycle
  // is spent capturing it and res_valid rises one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q    <= '0;
      row_q    <= '0;
      beat_cnt <= '0;
      row_cnt  <= '0;
      res_q    <= '0;
      cap_done <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (vec_fire) vec_q <= bus.vec_data;
      if (row_fire) row_q <= bus.row_data;
      if (state == STREAM)     beat_cnt <= (beat_cnt == LAST_BEAT)  ? '0 : beat_cnt + 1'b1;
      else if (state == DRAIN) beat_cnt <= (beat_cnt == LAST_DRAIN) ? '0 : beat_cnt + 1'b1;
      else                     beat_cnt <= '0;
      if ((state == OUT) && !cap_done) begin
        res_q    <= res_cap;
        cap_done <= 1'b1;
      end
      if (res_fire) begin
        cap_done <= 1'b0;
        if (row_cnt == LAST_ROW) begin
          row_cnt <= '0;
          done_q  <= 1'b1;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.vec_ready = 1'b0;
    bus.row_ready = 1'b0;
    bus.pe_en     = 1'b0;
    bus.pe_clr    = 1'b0;
    bus.pe_M      = '0;
    bus.pe_X      = '0;
    case (state)
      IDLE:   bus.vec_ready = 1'b1;
      LOAD:   bus.row_ready = 1'b1;
      CLR:    bus.pe_clr    = 1'b1;
      STREAM: begin
        bus.pe_en = 1'b1;
        bus.pe_M  = m_beat;
        bus.pe_X  = x_beat;
      end
      DRAIN:  bus.pe_en = 1'b1;
      default: ;
    endcase
  end

  assign bus.res_valid = (state == OUT) && cap_done;
  assign bus.res_data  = res_q;
  assign bus.res_row   = row_cnt;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Bench for pe_row_sequencer with a behavioural 3-stage PE; honours OBTC_HEAVYHASH_POST_EN.
module tb_pe_row_sequencer;
  import obtc_pkg::*;

  localparam int WCOUNT = 4;
  localparam int VLEN   = 64;
  localparam int ROWS   = 64;
  localparam int PE_LAT = 3;
  localparam int DW     = VLEN * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic pe_rst;
  always #5 clk = ~clk;

  pe_row_sequencer_if #(.WCOUNT(WCOUNT), .VLEN(VLEN), .ROWS(ROWS)) bus ();

  pe_row_sequencer #(.WCOUNT(WCOUNT), .VLEN(VLEN), .ROWS(ROWS), .PE_LAT(PE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- PE model: products -> sum -> stage -> accumulate, delayed clear ----
  logic        clr_d;
  logic [13:0] st_a, st_b, st_c, acc, prod_sum;

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < WCOUNT; i++)
      prod_sum = prod_sum + 14'(bus.pe_M[4*i +: 4]) * 14'(bus.pe_X[4*i +: 4]);
  end

  always_ff @(posedge clk) begin
    if (pe_rst) begin
      clr_d <= 1'b0; st_a <= '0; st_b <= '0; st_c <= '0; acc <= '0;
    end else begin
      clr_d <= bus.pe_clr;
      if (clr_d) begin
        st_a <= '0; st_b <= '0; st_c <= '0; acc <= '0;
      end else if (bus.pe_en) begin
        st_a <= prod_sum;
        st_b <= st_a;
        st_c <= st_b;
        acc  <= acc + st_c;
      end
    end
  end
  assign bus.pe_out = acc;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  logic [13:0] exp_q[$];
  logic [5:0]  exp_row_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [13:0] post(input int unsigned full);
`ifdef OBTC_HEAVYHASH_POST_EN
    return 14'(full >> 10);
`else
    return 14'(full);
`endif
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (!rst && bus.done) done_cnt++;
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got res_data %0d res_row %0d, expected no result", bus.res_data, bus.res_row);
      end else begin
        check("res_data", 32'(bus.res_data), 32'(exp_q.pop_front()));
        check("res_row", 32'(bus.res_row), 32'(exp_row_q.pop_front()));
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (enter and leave on a falling edge) ----------------
  function automatic logic [DW-1:0] mk_row(input bit ramp, input logic [3:0] nib);
    logic [DW-1:0] d;
    for (int i = 0; i < VLEN; i++) d[4*i +: 4] = ramp ? 4'(i % 16) : nib;
    return d;
  endfunction

  task automatic send_vec(input logic [3:0] nib);
    int t = 0;
    bus.vec_data  = {VLEN{nib}};
    bus.vec_valid = 1'b1;
    while (!bus.vec_ready && t < 100) begin @(negedge clk); t++; end
    check("vec_handshake", 32'(bus.vec_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.vec_valid = 1'b0;
  endtask

  task automatic send_row(input logic [DW-1:0] d, input int unsigned full, input int row);
    int t = 0;
    exp_q.push_back(post(full));
    exp_row_q.push_back(6'(row));
    bus.row_data  = d;
    bus.row_valid = 1'b1;
    while (!bus.row_ready && t < 100) begin @(negedge clk); t++; end
    check("row_handshake", 32'(bus.row_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.row_valid = 1'b0;
  endtask

  // Called on the falling edge after the row handshake edge; lat counts edges since it.
  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 60) begin @(negedge clk); lat++; end
  endtask

  task automatic take_res();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_job_end(input int done_before);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("vec_ready_after_job", 32'(bus.vec_ready), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("done_count", 32'(done_cnt - done_before), 32'd1);
  endtask

  task automatic run_job(input logic [3:0] vnib, input bit ramp, input logic [3:0] rnib,
                         input int unsigned full);
    int lat;
    int d0 = done_cnt;
    send_vec(vnib);
    for (int r = 0; r < ROWS; r++) begin
      send_row(mk_row(ramp, rnib), full, r);
      wait_res(lat);
      if (r == 0) check("first_row_latency", 32'(lat), 32'd22);
      take_res();
    end
    check_job_end(d0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  vec_nib;
    bit          row_ramp;
    logic [3:0]  row_nib;
    int unsigned full;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    int d0;

    tbl[0] = '{4'h1, 1'b0, 4'h1, 64};
    tbl[1] = '{4'hF, 1'b0, 4'hF, 14400};
    tbl[2] = '{4'h1, 1'b1, 4'h0, 480};
    tbl[3] = '{4'h2, 1'b0, 4'h3, 384};
    tbl[4] = '{4'hF, 1'b1, 4'h0, 7200};
    tbl[5] = '{4'h7, 1'b1, 4'h0, 3360};

    bus.vec_valid = 1'b0;
    bus.vec_data  = '0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    bus.res_ready = 1'b1;
    rst    = 1'b1;
    pe_rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_vec_ready", 32'(bus.vec_ready), 32'd1);
    check("rst_row_ready", 32'(bus.row_ready), 32'd0);
    check("rst_pe_ctl", {30'd0, bus.pe_en, bus.pe_clr}, 32'd0);
    check("rst_pe_M", 32'(bus.pe_M), 32'd0);
    check("rst_res", {17'd0, bus.res_valid, bus.res_data}, 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst    = 1'b0;
    pe_rst = 1'b0;
    @(negedge clk);

    // table-driven jobs
    for (int i = 0; i < 6; i++)
      run_job(tbl[i].vec_nib, tbl[i].row_ramp, tbl[i].row_nib, tbl[i].full);

    // row_valid withheld in LOAD, vec_valid mid-job, result backpressure
    d0 = done_cnt;
    send_vec(4'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("load_wait_quiet", {29'd0, bus.dbg_state == LOAD, bus.pe_clr, bus.pe_en}, 32'd4);
    end
    send_row(mk_row(1'b1, 4'h0), 480, 0);
    bus.vec_data  = {VLEN{4'hF}};
    bus.vec_valid = 1'b1;
    @(negedge clk);
    check("vec_ignored", 32'(bus.vec_ready), 32'd0);
    wait_res(lat);
    bus.vec_valid = 1'b0;
    take_res();

    bus.res_ready = 1'b0;
    send_row(mk_row(1'b0, 4'h3), 192, 1);
    wait_res(lat);
    check("bp_latency", 32'(lat), 32'd22);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {bus.res_valid, bus.row_ready, bus.pe_en, 9'd0, 6'(bus.res_row), bus.res_data},
                       {1'b1, 1'b0, 1'b0, 9'd0, 6'd1, post(192)});
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    take_res();
    for (int r = 2; r < ROWS; r++) begin
      send_row(mk_row(1'b1, 4'h0), 480, r);
      wait_res(lat);
      take_res();
    end
    check_job_end(d0);

    // reset during STREAM beat 7: beat slice check, then clean restart
    send_vec(4'h1);
    send_row(mk_row(1'b1, 4'h0), 480, 0);
    repeat (9) @(negedge clk);
    check("beat7_state", 32'(bus.dbg_state), 32'(STREAM));
    check("beat7_pe_M", 32'(bus.pe_M), 32'hFEDC);
    check("beat7_pe_X", 32'(bus.pe_X), 32'h1111);
    rst = 1'b1;
    exp_q.delete();
    exp_row_q.delete();
    @(negedge clk);
    check("midrst_vec_ready", 32'(bus.vec_ready), 32'd1);
    check("midrst_outputs", {bus.row_ready, bus.pe_en, bus.pe_clr, bus.res_valid, bus.done, 27'd0}, 32'd0);
    check("midrst_pe_M", 32'(bus.pe_M), 32'd0);
    check("midrst_res_data", 32'(bus.res_data), 32'd0);
    check("midrst_res_row", 32'(bus.res_row), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_job(4'h1, 1'b1, 4'h0, 480);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
